// File: rtl/gatebach_pkg.sv
// Shared definitions for the sieve result collector slice.
// Holds the default slice size, the bitmap word and address widths, and
// the collector state encoding.
package gatebach_pkg;

  localparam int unsigned SLICE_WORDS_DEF = 100;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned ADDR_W          = 7;
  localparam int unsigned IDX_W           = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SCAN,
    ST_DONE
  } collector_state_t;

endpackage

// File: rtl/gatebach_ffs.sv
// Combinational find-first-set over one bitmap word.
// Ports:
//   word  - word to search
//   idx   - index of the lowest set bit (0 when none set)
//   found - high when any bit of word is set
module gatebach_ffs
  import gatebach_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (!found && word[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sieve_result_collector.sv
// Collects one sieved slice bitmap from the sieve core, then emits the
// value of every set bit in ascending order over a valid/ready stream.
// Optional feature macro: GATEBACH_POPCOUNT_EN adds the prime_count output.
// Ports:
//   clk, i_rst_n  - clock, synchronous active-low reset
//   base_num      - value of bit 0 of word 0, latched on the first write
//   in_cs/in_add/in_data - bitmap word write strobe, address, data
//   out_valid/out_ready/out_prime - prime output stream
//   busy          - high while capturing or scanning
//   slice_done    - one-cycle pulse when the scan of a slice finishes
//   prime_count   - (GATEBACH_POPCOUNT_EN) primes accepted in this slice
module sieve_result_collector
  import gatebach_pkg::*;
#(
  parameter int unsigned SLICE_WORDS = SLICE_WORDS_DEF,
  parameter int unsigned BASE_W      = 64
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [BASE_W-1:0] base_num,
  input  logic              in_cs,
  input  logic [ADDR_W-1:0] in_add,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BASE_W-1:0] out_prime,
  output logic              busy,
  output logic              slice_done
`ifdef GATEBACH_POPCOUNT_EN
  ,
  output logic [11:0]       prime_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SLICE_WORDS - 1);

  collector_state_t  state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [WORD_W-1:0] cur_q, cur_d;

  logic [WORD_W-1:0] mem_q [SLICE_WORDS];
  logic              mem_we;

  logic [IDX_W-1:0]  ffs_idx;
  logic              ffs_found;
  logic              accept;
  logic [WORD_W-1:0] cur_clr;
  logic [ADDR_W-1:0] widx_nxt;

  gatebach_ffs u_ffs (
    .word  (cur_q),
    .idx   (ffs_idx),
    .found (ffs_found)
  );

  assign out_valid  = (state_q == ST_SCAN) && ffs_found;
  assign accept     = out_valid && out_ready;
  assign out_prime  = out_valid ? base_q + BASE_W'({widx_q, ffs_idx}) : '0;
  assign busy       = (state_q == ST_CAPTURE) || (state_q == ST_SCAN);
  assign slice_done = (state_q == ST_DONE);

  assign cur_clr  = cur_q & ~(WORD_W'(1) << ffs_idx);
  assign widx_nxt = (widx_q == LAST_ADDR) ? '0 : widx_q + 1'b1;
  assign mem_we   = in_cs && (in_add <= LAST_ADDR) &&
                    ((state_q == ST_IDLE) || (state_q == ST_CAPTURE));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    widx_d  = widx_q;
    cur_d   = cur_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_cs) begin
          state_d = ST_CAPTURE;
          base_d  = base_num;
        end
      end
      ST_CAPTURE: begin
        if (in_cs && (in_add == LAST_ADDR)) begin
          state_d = ST_SCAN;
          widx_d  = '0;
          // Preload word 0 so the first prime is visible in the first scan
          // cycle; a one-word slice is being written this very cycle.
          cur_d   = (LAST_ADDR == '0) ? in_data : mem_q[0];
        end
      end
      ST_SCAN: begin
        // A bit is retired only on acceptance; an empty word retires at once.
        if (!ffs_found || accept) begin
          if (!ffs_found || (cur_clr == '0)) begin
            if (widx_q == LAST_ADDR) begin
              state_d = ST_DONE;
              cur_d   = '0;
            end else begin
              widx_d = widx_nxt;
              cur_d  = mem_q[widx_nxt];
            end
          end else begin
            cur_d = cur_clr;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      widx_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      widx_q  <= widx_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[in_add] <= in_data;
    end
  end

`ifdef GATEBACH_POPCOUNT_EN
  logic [11:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((state_q == ST_IDLE) && in_cs) begin
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign prime_count = count_q;
`endif

endmodule
